// File: rtl/button_event_pkg.sv
// Shared event codes and FSM state encoding for the button event classifier.
// Also imported by the register-interface block that consumes these events.
package button_event_pkg;

    localparam logic [1:0] EV_NONE   = 2'd0;
    localparam logic [1:0] EV_CLICK  = 2'd1;
    localparam logic [1:0] EV_DOUBLE = 2'd2;
    localparam logic [1:0] EV_LONG   = 2'd3;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PRESS1 = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4,
        ST_PRESS2 = 3'd5
    } state_t;

endpackage

// File: rtl/button_event.sv
// Classifies a debounced button level into CLICK / DOUBLE / LONG events held in a
// one-entry valid/ready register. Optional timestamping: BUTTON_EVENT_TIMESTAMP_EN.
import button_event_pkg::*;

module button_event #(
    parameter int   LONG_CYCLES   = 1000000,
    parameter int   DOUBLE_CYCLES = 300000,
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    parameter int   TS_WIDTH      = 16,
`endif
    parameter logic ACTIVE_LEVEL  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in,
    output logic                event_valid,
    output logic [1:0]          event_code,
    input  logic                event_ready,
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    output logic [TS_WIDTH-1:0] event_time,
`endif
    output logic                overflow,
    output logic                busy
);

    localparam int MAX_CYCLES = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] DOUBLE_LAST = CW'(DOUBLE_CYCLES - 1);

    state_t        state, next_state;
    logic [CW-1:0] count;
    logic          act;
    logic          emit;
    logic [1:0]    emit_code;
    logic          load;

    assign act  = (in == ACTIVE_LEVEL);
    assign busy = (state != ST_IDLE) && (state != ST_ARM);
    assign load = emit && (!event_valid || event_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ARM;
            count <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                count <= '0;
            else if (count != '1)
                count <= count + 1'b1;
        end
    end

    // Input edges are tested before timeouts so a change on the timeout cycle wins.
    always_comb begin
        next_state = state;
        emit       = 1'b0;
        emit_code  = EV_NONE;
        case (state)
            ST_ARM:    if (!act) next_state = ST_IDLE;
            ST_IDLE:   if (act) next_state = ST_PRESS1;
            ST_PRESS1: begin
                if (!act) begin
                    next_state = ST_GAP;
                end else if (count == LONG_LAST) begin
                    emit       = 1'b1;
                    emit_code  = EV_LONG;
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD:   if (!act) next_state = ST_IDLE;
            ST_GAP: begin
                if (act) begin
                    next_state = ST_PRESS2;
                end else if (count == DOUBLE_LAST) begin
                    emit       = 1'b1;
                    emit_code  = EV_CLICK;
                    next_state = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!act) begin
                    emit       = 1'b1;
                    emit_code  = EV_DOUBLE;
                    next_state = ST_IDLE;
                end else if (count == LONG_LAST) begin
                    emit       = 1'b1;
                    emit_code  = EV_DOUBLE;
                    next_state = ST_HOLD;
                end
            end
            default:   next_state = ST_ARM;
        endcase
    end

    // A new event may load on the same edge the held one is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_valid <= 1'b0;
            event_code  <= EV_NONE;
            overflow    <= 1'b0;
        end else begin
            if (load) begin
                event_valid <= 1'b1;
                event_code  <= emit_code;
            end else if (event_valid && event_ready) begin
                event_valid <= 1'b0;
                event_code  <= EV_NONE;
            end
            if (emit && event_valid && !event_ready)
                overflow <= 1'b1;
        end
    end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_count   <= '0;
            event_time <= '0;
        end else begin
            ts_count <= ts_count + 1'b1;
            if (load)
                event_time <= ts_count;
        end
    end
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, DOUBLE_CYCLES=5.
// Timestamp checks are built only when BUTTON_EVENT_TIMESTAMP_EN is defined.
import button_event_pkg::*;

module tb_button_event;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_lvl = 1'b0;
    logic       ready = 1'b1;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overflow;
    logic       busy;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [3:0] event_time;
`endif

    int n_pass = 0;
    int n_total = 0;

    button_event #(
        .LONG_CYCLES   (8),
        .DOUBLE_CYCLES (5),
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        .TS_WIDTH      (4),
`endif
        .ACTIVE_LEVEL  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in_lvl),
        .event_valid (event_valid),
        .event_code  (event_code),
        .event_ready (ready),
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        .event_time  (event_time),
`endif
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One input sample per call; outputs are observed 1 time unit after the edge.
    task automatic step(input logic v);
        in_lvl = v;
        @(posedge clk);
        #1;
    endtask

    // Reset, then one released sample so the FSM sits in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        in_lvl = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0);
    endtask

    task automatic test_reset();
        in_lvl = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if ({event_valid, event_code, overflow, busy} !== 5'b0) $display("[TB] FAIL reset_outputs: got %b expected 00000", {event_valid, event_code, overflow, busy});
        else n_pass++;
        n_total++;
        if (dut.state !== ST_ARM) $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, ST_ARM);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            n_total++;
            if ({event_valid, busy} !== 2'b00) $display("[TB] FAIL arm_held_%0d: got valid/busy %b expected 00", i, {event_valid, busy});
            else n_pass++;
        end
        step(1'b0);
        n_total++;
        if (dut.state !== ST_IDLE) $display("[TB] FAIL arm_to_idle: got %0d expected %0d", dut.state, ST_IDLE);
        else n_pass++;
        n_total++;
        if ({event_valid, busy} !== 2'b00) $display("[TB] FAIL arm_release: got valid/busy %b expected 00", {event_valid, busy});
        else n_pass++;
    endtask

    task automatic test_click();
        do_reset();
        step(1'b1); step(1'b1); step(1'b1);
        n_total++;
        if (busy !== 1'b1) $display("[TB] FAIL click_busy: got %b expected 1", busy);
        else n_pass++;
        step(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            n_total++;
            if (event_valid !== 1'b0) $display("[TB] FAIL click_gap_%0d: got valid %b expected 0", i, event_valid);
            else n_pass++;
        end
        step(1'b0);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_CLICK}) $display("[TB] FAIL click_event: got %b expected %b", {event_valid, event_code}, {1'b1, EV_CLICK});
        else n_pass++;
        step(1'b0);
        n_total++;
        if ({event_valid, busy} !== 2'b00) $display("[TB] FAIL click_one_cycle: got valid/busy %b expected 00", {event_valid, busy});
        else n_pass++;
    endtask

    task automatic test_double();
        logic [7:0] pat;
        pat = 8'b1110_0111;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(pat[i]);
            n_total++;
            if (event_valid !== 1'b0) $display("[TB] FAIL double_pre_%0d: got valid %b expected 0", i, event_valid);
            else n_pass++;
        end
        step(1'b0);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_DOUBLE}) $display("[TB] FAIL double_event: got %b expected %b", {event_valid, event_code}, {1'b1, EV_DOUBLE});
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            n_total++;
            if (event_valid !== 1'b0) $display("[TB] FAIL double_no_click_%0d: got valid %b expected 0", i, event_valid);
            else n_pass++;
        end
    endtask

    task automatic test_long();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            n_total++;
            if (i == 9) begin
                if ({event_valid, event_code} !== {1'b1, EV_LONG}) $display("[TB] FAIL long_event: got %b expected %b", {event_valid, event_code}, {1'b1, EV_LONG});
                else n_pass++;
            end else begin
                if (event_valid !== 1'b0) $display("[TB] FAIL long_quiet_%0d: got valid %b expected 0", i, event_valid);
                else n_pass++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            n_total++;
            if (event_valid !== 1'b0) $display("[TB] FAIL long_release_%0d: got valid %b expected 0", i, event_valid);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("[TB] FAIL long_idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        ready = 1'b0;
        step(1'b1); step(1'b1); step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_CLICK}) $display("[TB] FAIL ovf_click: got %b expected %b", {event_valid, event_code}, {1'b1, EV_CLICK});
        else n_pass++;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1);
            n_total++;
            if ({event_code, overflow} !== {EV_CLICK, (i == 9)}) $display("[TB] FAIL ovf_hold_%0d: got code/ovf %b expected %b", i, {event_code, overflow}, {EV_CLICK, (i == 9)});
            else n_pass++;
        end
        step(1'b0);
        ready = 1'b1;
        step(1'b0);
        n_total++;
        if ({event_valid, overflow} !== 2'b01) $display("[TB] FAIL ovf_accept: got valid/ovf %b expected 01", {event_valid, overflow});
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (overflow !== 1'b0) $display("[TB] FAIL ovf_reset_clear: got %b expected 0", overflow);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'b1110_0111;
        do_reset();
        ready = 1'b0;
        step(1'b1); step(1'b1); step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        for (int i = 7; i >= 0; i--) step(pat[i]);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_CLICK}) $display("[TB] FAIL b2b_held: got %b expected %b", {event_valid, event_code}, {1'b1, EV_CLICK});
        else n_pass++;
        ready = 1'b1;
        step(1'b0);
        n_total++;
        if ({event_valid, event_code, overflow} !== {1'b1, EV_DOUBLE, 1'b0}) $display("[TB] FAIL b2b_load: got %b expected %b", {event_valid, event_code, overflow}, {1'b1, EV_DOUBLE, 1'b0});
        else n_pass++;
        step(1'b0);
        n_total++;
        if (event_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %b expected 0", event_valid);
        else n_pass++;
        // Reset while an event is held discards it.
        ready = 1'b0;
        step(1'b1); step(1'b1); step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({event_valid, event_code} !== 3'b000) $display("[TB] FAIL midop_reset: got %b expected 000", {event_valid, event_code});
        else n_pass++;
        rst_n = 1'b1;
        ready = 1'b1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1'b1); step(1'b1); step(1'b1); step(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0);
        step(1'b1);
        n_total++;
        if ({event_valid, busy} !== 2'b01) $display("[TB] FAIL gap_edge_no_click: got valid/busy %b expected 01", {event_valid, busy});
        else n_pass++;
        step(1'b1);
        step(1'b0);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_DOUBLE}) $display("[TB] FAIL gap_edge_double: got %b expected %b", {event_valid, event_code}, {1'b1, EV_DOUBLE});
        else n_pass++;

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1);
        step(1'b0);
        n_total++;
        if (event_valid !== 1'b0) $display("[TB] FAIL release_beats_long: got %b expected 0", event_valid);
        else n_pass++;
        for (int i = 0; i < 5; i++) step(1'b0);
        n_total++;
        if ({event_valid, event_code} !== {1'b1, EV_CLICK}) $display("[TB] FAIL release_then_click: got %b expected %b", {event_valid, event_code}, {1'b1, EV_CLICK});
        else n_pass++;

        do_reset();
        step(1'b1); step(1'b0); step(1'b1);
        for (int i = 0; i < 8; i++) step(1'b1);
        n_total++;
        if ({event_valid, event_code, busy} !== {1'b1, EV_DOUBLE, 1'b1}) $display("[TB] FAIL press2_long_double: got %b expected %b", {event_valid, event_code, busy}, {1'b1, EV_DOUBLE, 1'b1});
        else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        n_total++;
        if ({event_valid, busy} !== 2'b00) $display("[TB] FAIL press2_hold_release: got valid/busy %b expected 00", {event_valid, busy});
        else n_pass++;
    endtask

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [7:0] pat;
        pat = 8'b1110_0111;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0);
        step(1'b1); step(1'b1); step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        n_total++;
        if ({event_valid, event_time} !== {1'b1, 4'd15}) $display("[TB] FAIL ts_click: got %b expected %b", {event_valid, event_time}, {1'b1, 4'd15});
        else n_pass++;
        step(1'b0);
        for (int i = 7; i >= 0; i--) step(pat[i]);
        step(1'b0);
        n_total++;
        if ({event_valid, event_code, event_time} !== {1'b1, EV_DOUBLE, 4'd9}) $display("[TB] FAIL ts_wrap: got %b expected %b", {event_valid, event_code, event_time}, {1'b1, EV_DOUBLE, 4'd9});
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_click();
        test_double();
        test_long();
        test_overflow();
        test_back_to_back();
        test_simultaneous();
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the single-bit level produced by the debounce stage and classifies press activity into discrete events: CLICK, DOUBLE, LONG.
- Sits between the debounce stage and the register/host interface.
- Events are presented through a one-entry valid/ready holding register.
- Events that arrive while that register is occupied are dropped and flagged.

Parameters:
LONG_CYCLES, 1000000, cycles the input must stay active for a press to count as LONG (>=2)
DOUBLE_CYCLES, 300000, maximum idle gap, in cycles, after a first release for a second press to count (>=2)
ACTIVE_LEVEL, 1, input level treated as "pressed"
TS_WIDTH, 16, timestamp width (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in  in  1  debounced button level
event_valid  out  1  event held in the output register
event_code  out  2  event type: 0 none, 1 CLICK, 2 DOUBLE, 3 LONG
event_ready  in  1  consumer accepts the event when valid&&ready
overflow  out  1  sticky flag: an event was dropped; cleared only by reset
busy  out  1  FSM is not in IDLE or ARM

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: event_valid=0, event_code=0, overflow=0, busy=0.
  - Internal: state=ARM, counter=0.
- Definition: act = (in == ACTIVE_LEVEL).
- Counter:
  - Width = $clog2(max(LONG_CYCLES, DOUBLE_CYCLES)+1).
  - Saturating; cleared on every state change.
- FSM states and transitions:
  - ARM: wait for !act, then go to IDLE. A button held through reset produces no event.
  - IDLE: act -> PRESS1.
  - PRESS1:
    - !act -> GAP.
    - counter == LONG_CYCLES-1 with act still high -> emit LONG, go to HOLD.
  - HOLD: !act -> IDLE. No further event.
  - GAP:
    - act -> PRESS2.
    - counter == DOUBLE_CYCLES-1 -> emit CLICK, go to IDLE.
  - PRESS2:
    - !act -> emit DOUBLE, go to IDLE.
    - counter == LONG_CYCLES-1 -> emit DOUBLE, go to HOLD. LONG is never emitted after a second press.
- Emission:
  - The event is registered: event_valid rises on the clock edge after the triggering condition.
  - Latency is 1 cycle from the in-sample that triggers it.
- Handshake:
  - event_valid/event_code stay stable until the cycle where valid&&ready.
  - The register clears on that edge unless a new event is emitted on the same edge. In that case the new event loads (back-to-back; no bubble required).
- Overflow: an emission while event_valid=1 and event_ready=0 drops the new event and sets overflow=1. The held event is unchanged.
- Simultaneous cases:
  - Timeout and input change on the same cycle: the input change wins. Example: in GAP, act at counter == DOUBLE_CYCLES-1 goes to PRESS2, with no CLICK emitted.
  - Release on the same cycle LONG would trigger: the release wins.
- Reset mid-operation: any in-flight event and the held event are discarded, and the FSM returns to ARM.

Optional Feature:
- Macro: BUTTON_EVENT_TIMESTAMP_EN.
- When defined:
  - Adds output event_time [TS_WIDTH-1:0] and a free-running wrap-around TS_WIDTH counter, reset to 0.
  - event_time captures the counter value on the same edge event_valid loads, and is held with the event.
  - Dropped events do not update it.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package button_event_pkg:
  - Event code localparams EV_NONE/EV_CLICK/EV_DOUBLE/EV_LONG.
  - State encoding ST_ARM..ST_PRESS2.
  - Also consumed by the register-interface block.
- No sub-module: the counter and holding register stay inline. The block is too small to justify splitting.

Test Plan:
Bench parameters: LONG_CYCLES=8, DOUBLE_CYCLES=5, ready tied 1 unless stated.
- Reset with in=1, release reset, hold 20 cycles, drop in -> no event, busy=0 throughout, FSM reaches IDLE.
- in=1 for 3 cycles, then 0 -> after 5 gap cycles, event_valid=1 and event_code=1 for exactly 1 cycle.
- in=1 for 3 cycles, 0 for 2, 1 for 3, 0 -> single event_code=2, one cycle after the second release. No CLICK.
- in=1 for 12 cycles -> event_code=3 one cycle after the 8th active cycle. Release produces nothing.
- ready=0: CLICK, then LONG -> CLICK held, LONG dropped, overflow=1. Raise ready -> CLICK accepted, overflow stays 1.
- With BUTTON_EVENT_TIMESTAMP_EN, TS_WIDTH=4: emit CLICK at time counter 15 -> event_time=15. Next event after wrap -> small value, no X.
